// File: rtl/cordic_pkg.sv
// cordic_pkg
// Shared constants and types for the CORDIC sin/cos sequencer.
//   W, AW        datapath width (x/y/z, Q1.11) and input angle width
//   ITERATIONS   CORDIC passes (<= 10, so the pass counter fits CNT_W bits)
//   K_INIT       x seed, CORDIC gain 0.60725 in Q1.11
//   DEGxx        angle landmarks in 1/64 degree units
//   state_t      sequencer states
//   neg_sat      two's complement negate that clamps -(min) to max
package cordic_pkg;

  localparam int W          = 13;
  localparam int AW         = 16;
  localparam int ITERATIONS = 10;
  localparam int CNT_W      = 4;

  localparam logic signed [W-1:0] K_INIT = 13'sd1244;

  localparam int DEG45  = 2880;
  localparam int DEG90  = 5760;
  localparam int DEG135 = 8640;
  localparam int DEG180 = 11520;
  localparam int DEG360 = 23040;

  typedef enum logic [2:0] {
    IDLE,
    WRAP,
    QUAD,
    ITER,
    MAP,
    DONE
  } state_t;

  // The most negative code has no positive counterpart in W bits, so it
  // clamps to the most positive code instead of wrapping back onto itself.
  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    if (v == most_neg) begin
      neg_sat = ~most_neg;
    end else begin
      neg_sat = -v;
    end
  endfunction

endpackage

// File: rtl/cordic_quadrant_map.sv
// cordic_quadrant_map
// Rotates the CORDIC result (computed for the residual angle in [-45,45) deg)
// back by k quarter turns to recover cos/sin of the full angle.
//   k        in   2  quarter-turn count from the angle reduction
//   c, s     in   W  cos/sin of the residual angle (Q1.11)
//   cos_val  out  W  cos of the full angle (Q1.11)
//   sin_val  out  W  sin of the full angle (Q1.11)
module cordic_quadrant_map
  import cordic_pkg::*;
(
  input  logic [1:0]          k,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] s,
  output logic signed [W-1:0] cos_val,
  output logic signed [W-1:0] sin_val
);

  // Adding k*90 deg: cos(r+90)=-sin r, sin(r+90)=cos r, and so on around the
  // circle; every negation goes through the saturating helper.
  always_comb begin
    cos_val = c;
    sin_val = s;
    unique case (k)
      2'd0: begin
        cos_val = c;
        sin_val = s;
      end
      2'd1: begin
        cos_val = neg_sat(s);
        sin_val = c;
      end
      2'd2: begin
        cos_val = neg_sat(c);
        sin_val = neg_sat(s);
      end
      2'd3: begin
        cos_val = s;
        sin_val = neg_sat(c);
      end
      default: begin
        cos_val = c;
        sin_val = s;
      end
    endcase
  end

endmodule

// File: rtl/cordic_sincos_ctrl.sv
// cordic_sincos_ctrl
// Front end and sequencer for an external single-cycle CORDIC iteration stage.
// Reduces the input angle to a quadrant plus a residual in [-45,45) deg, runs
// ITERATIONS passes through the external datapath and returns cos/sin on a
// valid/ready output.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     angle request handshake (ready only in IDLE)
//   in_angle              signed angle, 1/64 deg
//   out_valid/out_ready   result handshake, result held until accepted
//   out_cos, out_sin      Q1.11 results
//   busy                  sequencer not idle
//   cd_x0/y0/z0, cd_stage operands and pass index to the iteration datapath
//   cd_xn/yn/zn           datapath results, registered one cycle after operands
module cordic_sincos_ctrl
  import cordic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [AW-1:0] in_angle,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_cos,
  output logic signed [W-1:0]  out_sin,
  output logic                 busy,
  output logic signed [W-1:0]  cd_x0,
  output logic signed [W-1:0]  cd_y0,
  output logic signed [W-1:0]  cd_z0,
  output logic [31:0]          cd_stage,
  input  logic signed [W-1:0]  cd_xn,
  input  logic signed [W-1:0]  cd_yn,
  input  logic signed [W-1:0]  cd_zn
);

  localparam logic signed [AW-1:0] A45  = AW'(DEG45);
  localparam logic signed [AW-1:0] A90  = AW'(DEG90);
  localparam logic signed [AW-1:0] A135 = AW'(DEG135);
  localparam logic signed [AW-1:0] A180 = AW'(DEG180);
  localparam logic signed [AW-1:0] A360 = AW'(DEG360);
  localparam logic [CNT_W-1:0]     LAST = CNT_W'(ITERATIONS - 1);

  state_t               state;
  state_t               state_nx;
  logic signed [AW-1:0] a;
  logic [1:0]           k;
  logic signed [W-1:0]  r;
  logic [CNT_W-1:0]     iter_cnt;
  logic                 wrap_hi;
  logic                 wrap_lo;
  logic signed [W-1:0]  map_cos;
  logic signed [W-1:0]  map_sin;

  // The input range is about +-512 deg, so one 360 deg step per WRAP cycle
  // always lands inside [-180,180) after at most two adjustments.
  assign wrap_hi = (a >= A180);
  assign wrap_lo = (a < -A180);

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  cordic_quadrant_map u_map (
    .k       (k),
    .c       (cd_xn),
    .s       (cd_yn),
    .cos_val (map_cos),
    .sin_val (map_sin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the datapath operands; the datapath only sees non-zero
  // operands while iterating, pass 0 is seeded from the reduced angle and
  // later passes simply feed the previous result back.
  always_comb begin
    state_nx = state;
    cd_x0    = '0;
    cd_y0    = '0;
    cd_z0    = '0;
    cd_stage = '0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nx = WRAP;
      end
      WRAP: begin
        if (!wrap_hi && !wrap_lo) state_nx = QUAD;
      end
      QUAD: begin
        state_nx = ITER;
      end
      ITER: begin
        if (iter_cnt == '0) begin
          cd_x0 = K_INIT;
          cd_z0 = r;
        end else begin
          cd_x0    = cd_xn;
          cd_y0    = cd_yn;
          cd_z0    = cd_zn;
          cd_stage = {{(32-CNT_W){1'b0}}, iter_cnt};
        end
        if (iter_cnt == LAST) state_nx = MAP;
      end
      MAP: begin
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Angle reduction, pass counter and result capture. Each residual formula
  // keeps r inside [-2880,2880), so truncation to W bits loses nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      k        <= '0;
      r        <= '0;
      iter_cnt <= '0;
      out_cos  <= '0;
      out_sin  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) a <= in_angle;
        end
        WRAP: begin
          if (wrap_hi) begin
            a <= a - A360;
          end else if (wrap_lo) begin
            a <= a + A360;
          end
        end
        QUAD: begin
          iter_cnt <= '0;
          if (a >= A135) begin
            k <= 2'd2;
            r <= W'(a - A180);
          end else if (a >= A45) begin
            k <= 2'd1;
            r <= W'(a - A90);
          end else if (a >= -A45) begin
            k <= 2'd0;
            r <= W'(a);
          end else if (a >= -A135) begin
            k <= 2'd3;
            r <= W'(a + A90);
          end else begin
            k <= 2'd2;
            r <= W'(a + A180);
          end
        end
        ITER: begin
          iter_cnt <= iter_cnt + 1'b1;
        end
        MAP: begin
          out_cos <= map_cos;
          out_sin <= map_sin;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// tb_cordic_sincos_ctrl
// Directed bench for the CORDIC sequencer. A behavioural rotation-mode
// iteration stage closes the loop on cd_*; expected cos/sin, residual angle
// and latency for each request are hand-computed constants in a table.
module tb_cordic_sincos_ctrl;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_angle;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out_cos;
  logic signed [12:0] out_sin;
  logic               busy;
  logic signed [12:0] cd_x0;
  logic signed [12:0] cd_y0;
  logic signed [12:0] cd_z0;
  logic [31:0]        cd_stage;
  logic signed [12:0] cd_xn;
  logic signed [12:0] cd_yn;
  logic signed [12:0] cd_zn;

  typedef struct packed {
    int angle;
    int exp_cos;
    int exp_sin;
    int exp_r;
    int exp_lat;
    int tol;
    bit sat;
  } vec_t;

  vec_t vecs[16];
  int   n_vec = 0;
  int   n_miss = 0;
  bit   sat_mode = 1'b0;
  int   atan_tab[10];
  int   mx, my, mz, ms, sx, sy, nx, ny, nz;
  int   lat;

  always #5 clk = ~clk;

  cordic_sincos_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .busy      (busy),
    .cd_x0     (cd_x0),
    .cd_y0     (cd_y0),
    .cd_z0     (cd_z0),
    .cd_stage  (cd_stage),
    .cd_xn     (cd_xn),
    .cd_yn     (cd_yn),
    .cd_zn     (cd_zn)
  );

  // Behavioural iteration stage: rotate towards z=0 with d=sign(z), round the
  // shifted terms to keep truncation drift inside the tolerance. In sat mode
  // the last pass returns the most negative code to exercise clamping.
  always @(posedge clk) begin
    mx = int'(cd_x0);
    my = int'(cd_y0);
    mz = int'(cd_z0);
    ms = int'(cd_stage);
    if (ms > 9) ms = 9;
    sx = (ms == 0) ? mx : ((mx + (1 <<< (ms - 1))) >>> ms);
    sy = (ms == 0) ? my : ((my + (1 <<< (ms - 1))) >>> ms);
    if (mz >= 0) begin
      nx = mx - sy;
      ny = my + sx;
      nz = mz - atan_tab[ms];
    end else begin
      nx = mx + sy;
      ny = my - sx;
      nz = mz + atan_tab[ms];
    end
    if (sat_mode && ms == 9) begin
      nx = -4096;
      ny = -4096;
    end
    cd_xn <= 13'(nx);
    cd_yn <= 13'(ny);
    cd_zn <= 13'(nz);
  end

  // One comparison: counts it and reports a FAIL line when |actual-required|
  // exceeds the tolerance.
  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    n_vec++;
    if (diff > tol) begin
      n_miss++;
      $display("[TB] FAIL %s: actual %0d, required %0d (tol %0d)", name, actual, expected, tol);
    end
  endtask

  // Issues one request and counts edges from the accept edge until out_valid.
  // Also probes the first and last iteration passes, and can pulse a second
  // in_valid (angle 100) at a chosen cycle to show it is ignored.
  task automatic applyStimulus(input vec_t v, input int pulse_at, output int lat_o);
    int it0;
    sat_mode = v.sat;
    it0 = v.exp_lat - 11;
    @(negedge clk);
    checkOutput($sformatf("a=%0d in_ready before accept", v.angle), int'(in_ready), 1, 0);
    in_valid = 1'b1;
    in_angle = 16'(v.angle);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat_o = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == it0) begin
        checkOutput($sformatf("a=%0d pass0 cd_stage", v.angle), int'(cd_stage), 0, 0);
        checkOutput($sformatf("a=%0d pass0 cd_x0", v.angle), int'(cd_x0), 1244, 0);
        checkOutput($sformatf("a=%0d pass0 cd_y0", v.angle), int'(cd_y0), 0, 0);
        checkOutput($sformatf("a=%0d pass0 cd_z0 residual", v.angle), int'(cd_z0), v.exp_r, 0);
        checkOutput($sformatf("a=%0d in_ready while busy", v.angle), int'(in_ready), 0, 0);
      end
      if (c == it0 + 9) begin
        checkOutput($sformatf("a=%0d last pass cd_stage", v.angle), int'(cd_stage), 9, 0);
      end
      if (c == pulse_at) begin
        in_valid = 1'b1;
        in_angle = 16'sd100;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        lat_o = c;
        break;
      end
    end
    in_valid = 1'b0;
    checkOutput($sformatf("a=%0d latency", v.angle), lat_o, v.exp_lat, 0);
    checkOutput($sformatf("a=%0d cos", v.angle), int'(out_cos), v.exp_cos, v.tol);
    checkOutput($sformatf("a=%0d sin", v.angle), int'(out_sin), v.exp_sin, v.tol);
  endtask

  // Handshake with out_ready already high: the result is taken on the next
  // edge and the block is ready again right after it.
  task automatic acceptResult(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid after handshake"}, int'(out_valid), 0, 0);
    checkOutput({tag, " in_ready after handshake"}, int'(in_ready), 1, 0);
  endtask

  // Main sequence: reset checks, the vector table, then the back-pressure,
  // ignored-request and mid-run reset corner cases.
  initial begin
    atan_tab = '{2880, 1700, 898, 456, 229, 115, 57, 29, 14, 7};
    //            angle   cos    sin     r   lat tol sat
    vecs[0]  = '{     0,  2048,     0,     0, 13, 8, 1'b0};
    vecs[1]  = '{  5760,     0,  2048,     0, 13, 8, 1'b0};
    vecs[2]  = '{-11520, -2048,     0,     0, 13, 8, 1'b0};
    vecs[3]  = '{ 28800,     0,  2048,     0, 14, 8, 1'b0};
    // -512 deg needs one +360 step to land at -152 deg
    vecs[4]  = '{-32768, -1808,  -961,  1792, 14, 8, 1'b0};
    vecs[5]  = '{  1920,  1774,  1024,  1920, 13, 8, 1'b0};
    vecs[6]  = '{ -2880,  1448, -1448, -2880, 13, 8, 1'b0};
    vecs[7]  = '{  8640, -1448,  1448, -2880, 13, 8, 1'b0};
    vecs[8]  = '{ -5760,     0, -2048,     0, 13, 8, 1'b0};
    vecs[9]  = '{ 11519, -2048,     1,    -1, 13, 8, 1'b0};
    vecs[10] = '{ 11520, -2048,     0,     0, 14, 8, 1'b0};
    vecs[11] = '{ 32767, -1808,   962, -1793, 14, 8, 1'b0};
    vecs[12] = '{  4800,   530,  1978,  -960, 13, 8, 1'b0};
    vecs[13] = '{ -7000,  -679, -1932, -1240, 13, 8, 1'b0};
    vecs[14] = '{  5760,  4095, -4096,     0, 13, 0, 1'b1};
    vecs[15] = '{-11520,  4095,  4095,     0, 13, 0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", int'(in_ready), 1, 0);
    checkOutput("reset out_valid", int'(out_valid), 0, 0);
    checkOutput("reset busy", int'(busy), 0, 0);
    checkOutput("reset out_cos", int'(out_cos), 0, 0);
    checkOutput("reset out_sin", int'(out_sin), 0, 0);
    checkOutput("reset cd_x0", int'(cd_x0), 0, 0);
    checkOutput("reset cd_y0", int'(cd_y0), 0, 0);
    checkOutput("reset cd_z0", int'(cd_z0), 0, 0);
    checkOutput("reset cd_stage", int'(cd_stage), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], -1, lat);
      acceptResult($sformatf("vec%0d", i));
    end

    // Back-pressure: result held for 5 cycles, no new request accepted.
    $display("[TB] back-pressure in DONE");
    out_ready = 1'b0;
    applyStimulus(vecs[5], -1, lat);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold%0d out_valid", j), int'(out_valid), 1, 0);
      checkOutput($sformatf("hold%0d in_ready", j), int'(in_ready), 0, 0);
      checkOutput($sformatf("hold%0d cos", j), int'(out_cos), vecs[5].exp_cos, 8);
      checkOutput($sformatf("hold%0d sin", j), int'(out_sin), vecs[5].exp_sin, 8);
    end
    out_ready = 1'b1;
    acceptResult("hold");

    // A request raised mid-iteration must be dropped entirely.
    $display("[TB] in_valid pulse while busy");
    applyStimulus(vecs[0], 5, lat);
    acceptResult("pulse");
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("pulse idle%0d out_valid", j), int'(out_valid), 0, 0);
      checkOutput($sformatf("pulse idle%0d busy", j), int'(busy), 0, 0);
    end

    // Reset asserted at iteration pass 4 clears everything immediately.
    $display("[TB] reset during iteration");
    sat_mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = 16'sd4800;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("mid-reset pass index", int'(cd_stage), 4, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset out_valid", int'(out_valid), 0, 0);
    checkOutput("mid-reset in_ready", int'(in_ready), 1, 0);
    checkOutput("mid-reset busy", int'(busy), 0, 0);
    checkOutput("mid-reset cd_x0", int'(cd_x0), 0, 0);
    checkOutput("mid-reset cd_y0", int'(cd_y0), 0, 0);
    checkOutput("mid-reset cd_z0", int'(cd_z0), 0, 0);
    checkOutput("mid-reset cd_stage", int'(cd_stage), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post-reset out_valid", int'(out_valid), 0, 0);
    applyStimulus(vecs[12], -1, lat);
    acceptResult("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
